// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the byte-lane data memory.
// slave = arbiter side, master = requesters plus memory side.
interface dmem_port_arbiter_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
);
   logic              a_req_i;
   logic              a_we_i;
   logic [1:0]        a_size_i;
   logic              a_uns_i;
   logic [ADDR_W-1:0] a_addr_i;
   logic [DATA_W-1:0] a_wdata_i;
   logic              a_gnt_o;
   logic              a_rvalid_o;
   logic [DATA_W-1:0] a_rdata_o;
   logic              a_err_o;

   logic              b_req_i;
   logic              b_we_i;
   logic [1:0]        b_size_i;
   logic              b_uns_i;
   logic [ADDR_W-1:0] b_addr_i;
   logic [DATA_W-1:0] b_wdata_i;
   logic              b_gnt_o;
   logic              b_rvalid_o;
   logic [DATA_W-1:0] b_rdata_o;
   logic              b_err_o;

   logic [3:0]        mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [DATA_W-1:0] mem_rdata_i;

   modport slave (
      input  a_req_i, a_we_i, a_size_i, a_uns_i, a_addr_i, a_wdata_i,
      output a_gnt_o, a_rvalid_o, a_rdata_o, a_err_o,
      input  b_req_i, b_we_i, b_size_i, b_uns_i, b_addr_i, b_wdata_i,
      output b_gnt_o, b_rvalid_o, b_rdata_o, b_err_o,
      output mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i
   );

   modport master (
      output a_req_i, a_we_i, a_size_i, a_uns_i, a_addr_i, a_wdata_i,
      input  a_gnt_o, a_rvalid_o, a_rdata_o, a_err_o,
      output b_req_i, b_we_i, b_size_i, b_uns_i, b_addr_i, b_wdata_i,
      input  b_gnt_o, b_rvalid_o, b_rdata_o, b_err_o,
      input  mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port data-memory arbiter: A has priority, B is protected by a starvation counter.
// Handles lane enables, store replication, alignment errors and load extension.
module dmem_port_arbiter #(
   parameter int ADDR_W     = 14,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input logic                clk,
   input logic                rst,
   dmem_port_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   typedef enum logic {IDLE = 1'b0, RD_RESP = 1'b1} state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  starve_q, starve_d;
   logic              id_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        rvalid_q;
   logic [1:0]        err_q;
   logic [DATA_W-1:0] rdata_q [2];

   logic [1:0]        req;
   logic [1:0]        gnt;
   logic              any_gnt;
   logic              sel_b;
   logic              starved;
   logic              w_we;
   logic [1:0]        w_size;
   logic              w_uns;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic              legal;
   logic [3:0]        lane_mask;

   function automatic logic [DATA_W-1:0] extend(input logic [1:0] size, input logic uns,
                                                input logic [DATA_W-1:0] d);
      case (size)
         2'b00:   extend = {{24{~uns & d[7]}}, d[7:0]};
         2'b01:   extend = {{16{~uns & d[15]}}, d[15:0]};
         default: extend = d;
      endcase
   endfunction

   assign req     = {bus.b_req_i, bus.a_req_i};
   assign starved = (starve_q == CNT_W'(STARVE_MAX));

   // Grants are gated by rst so nothing leaks to memory while reset is asserted.
   assign gnt[0]  = !rst && (state_q == IDLE) && req[0] && (!req[1] || !starved);
   assign gnt[1]  = !rst && (state_q == IDLE) && req[1] && (!req[0] || starved);
   assign any_gnt = |gnt;
   assign sel_b   = gnt[1];

   assign w_we    = sel_b ? bus.b_we_i    : bus.a_we_i;
   assign w_size  = sel_b ? bus.b_size_i  : bus.a_size_i;
   assign w_uns   = sel_b ? bus.b_uns_i   : bus.a_uns_i;
   assign w_addr  = sel_b ? bus.b_addr_i  : bus.a_addr_i;
   assign w_wdata = sel_b ? bus.b_wdata_i : bus.a_wdata_i;

   always_comb begin
      legal     = 1'b0;
      lane_mask = 4'h0;
      case (w_size)
         2'b00: begin
            legal     = 1'b1;
            lane_mask = 4'b0001 << w_addr[1:0];
         end
         2'b01: begin
            legal     = ~w_addr[0];
            lane_mask = 4'b0011 << w_addr[1:0];
         end
         2'b10: begin
            legal     = (w_addr[1:0] == 2'b00);
            lane_mask = 4'hF;
         end
         default: begin
            legal     = 1'b0;
            lane_mask = 4'h0;
         end
      endcase
   end

   always_comb begin
      case (w_size)
         2'b00:   bus.mem_wdata_o = {4{w_wdata[7:0]}};
         2'b01:   bus.mem_wdata_o = {2{w_wdata[15:0]}};
         default: bus.mem_wdata_o = w_wdata;
      endcase
   end

   assign bus.mem_we_o   = (any_gnt && legal && w_we) ? lane_mask : 4'h0;
   assign bus.mem_addr_o = (state_q == RD_RESP) ? addr_q : w_addr;

   always_comb begin
      starve_d = starve_q;
      if (gnt[1] || !req[1]) begin
         starve_d = '0;
      end else if (gnt[0] && !starved) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         starve_q   <= '0;
         id_q       <= 1'b0;
         size_q     <= 2'b00;
         uns_q      <= 1'b0;
         addr_q     <= '0;
         rvalid_q   <= 2'b00;
         err_q      <= 2'b00;
         rdata_q[0] <= '0;
         rdata_q[1] <= '0;
      end else begin
         starve_q   <= starve_d;
         err_q      <= gnt & {2{~legal}};
         rvalid_q   <= 2'b00;
         rdata_q[0] <= '0;
         rdata_q[1] <= '0;
         case (state_q)
            IDLE: begin
               if (any_gnt && legal && !w_we) begin
                  state_q <= RD_RESP;
                  id_q    <= sel_b;
                  size_q  <= w_size;
                  uns_q   <= w_uns;
                  addr_q  <= w_addr;
               end
            end
            RD_RESP: begin
               // Memory data for the held address is valid now; register it for the winner.
               state_q           <= IDLE;
               rvalid_q[id_q]    <= 1'b1;
               rdata_q[id_q]     <= extend(size_q, uns_q, bus.mem_rdata_i);
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.a_gnt_o    = gnt[0];
   assign bus.b_gnt_o    = gnt[1];
   assign bus.a_rvalid_o = rvalid_q[0];
   assign bus.b_rvalid_o = rvalid_q[1];
   assign bus.a_rdata_o  = rdata_q[0];
   assign bus.b_rdata_o  = rdata_q[1];
   assign bus.a_err_o    = err_q[0];
   assign bus.b_err_o    = err_q[1];
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus random single-port traffic
// checked against a byte-array reference memory.
module tb_dmem_port_arbiter;
   localparam int ADDR_W     = 14;
   localparam int DATA_W     = 32;
   localparam int STARVE_MAX = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mem_init = 1'b1;
   int   checks = 0;
   int   passes = 0;

   dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

   dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] mem_b [0:255];
   logic [7:0] ref_b [0:255];

   function automatic logic [7:0] init_byte(int a);
      return 8'((a * 61 + 17) ^ 8'h3C);
   endfunction

   function automatic logic [31:0] mem_read(logic [ADDR_W-1:0] ad);
      logic [7:0]  base;
      logic [31:0] w;
      base = {ad[7:2], 2'b00};
      w = {mem_b[base+3], mem_b[base+2], mem_b[base+1], mem_b[base]};
      return w >> (8 * ad[1:0]);
   endfunction

   // Synchronous memory: lane writes and a registered, right-aligned read.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int a = 0; a < 256; a++) mem_b[a] <= init_byte(a);
      end else begin
         for (int k = 0; k < 4; k++)
            if (bus.mem_we_o[k]) mem_b[{bus.mem_addr_o[7:2], 2'(k)}] <= bus.mem_wdata_o[8*k +: 8];
      end
      bus.mem_rdata_i <= mem_read(bus.mem_addr_o);
   end

   initial begin
      #300000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- reference model ----------------
   function automatic int nbytes(logic [1:0] s);
      return 1 << s;
   endfunction

   function automatic bit is_legal(logic [1:0] s, logic [ADDR_W-1:0] a);
      return (s != 2'b11) && ((int'(a) % nbytes(s)) == 0);
   endfunction

   function automatic logic [3:0] exp_mask(bit we, logic [1:0] s, logic [ADDR_W-1:0] a);
      if (!we || !is_legal(s, a)) return 4'h0;
      return 4'(((1 << nbytes(s)) - 1) << a[1:0]);
   endfunction

   function automatic logic [31:0] exp_wdata(logic [1:0] s, logic [31:0] wd);
      logic [31:0] r;
      int n;
      n = nbytes(s);
      for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % n) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] exp_load(logic [1:0] s, bit uns, logic [ADDR_W-1:0] a);
      longint v;
      int n;
      n = nbytes(s);
      v = 0;
      for (int i = 0; i < n; i++) v = v | (longint'(ref_b[8'(int'(a) + i)]) << (8 * i));
      if (!uns && v[8*n-1]) v = v - (longint'(1) << (8 * n));
      return v[31:0];
   endfunction

   task automatic ref_store(logic [1:0] s, logic [ADDR_W-1:0] a, logic [31:0] wd);
      for (int i = 0; i < nbytes(s); i++) ref_b[8'(int'(a) + i)] = wd[8*i +: 8];
   endtask

   // ---------------- helpers ----------------
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   function automatic logic gnt_of(bit p);   return p ? bus.b_gnt_o    : bus.a_gnt_o;    endfunction
   function automatic logic rv_of(bit p);    return p ? bus.b_rvalid_o : bus.a_rvalid_o; endfunction
   function automatic logic err_of(bit p);   return p ? bus.b_err_o    : bus.a_err_o;    endfunction
   function automatic logic [31:0] rd_of(bit p); return p ? bus.b_rdata_o : bus.a_rdata_o; endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(bit p, bit req, bit we, logic [1:0] s, bit uns,
                        logic [ADDR_W-1:0] a, logic [31:0] wd);
      if (!p) begin
         bus.a_req_i = req; bus.a_we_i = we; bus.a_size_i = s;
         bus.a_uns_i = uns; bus.a_addr_i = a; bus.a_wdata_i = wd;
      end else begin
         bus.b_req_i = req; bus.b_we_i = we; bus.b_size_i = s;
         bus.b_uns_i = uns; bus.b_addr_i = a; bus.b_wdata_i = wd;
      end
   endtask

   task automatic clear_reqs();
      drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
   endtask

   // One single-port transaction, checked end to end against the model.
   task automatic do_txn(bit p, bit we, logic [1:0] s, bit uns, logic [ADDR_W-1:0] a,
                         logic [31:0] wd, output int waited, output logic [3:0] o_we,
                         output logic [31:0] o_wd, output logic [31:0] o_rd);
      bit lg;
      lg = is_legal(s, a);
      o_rd = '0;
      step();
      drive(p, 1'b1, we, s, uns, a, wd);
      waited = 0;
      @(negedge clk);
      while (!gnt_of(p) && waited < 8) begin
         step();
         @(negedge clk);
         waited++;
      end
      chk("gnt", 32'(gnt_of(p)), 32'd1);
      o_we = bus.mem_we_o;
      o_wd = bus.mem_wdata_o;
      chk("mem_addr", 32'(bus.mem_addr_o), 32'(a));
      chk("mem_we", 32'(bus.mem_we_o), 32'(exp_mask(we, s, a)));
      if (we && lg) chk("mem_wdata", bus.mem_wdata_o, exp_wdata(s, wd));
      step();
      drive(p, 1'b0, we, s, uns, a ^ 14'h2A, wd);
      @(negedge clk);
      chk("err", 32'(err_of(p)), 32'(!lg));
      chk("rvalid_early", 32'(rv_of(p)), 32'd0);
      if (lg && !we) begin
         chk("rd_addr_hold", 32'(bus.mem_addr_o), 32'(a));
         step();
         @(negedge clk);
         chk("rvalid", 32'(rv_of(p)), 32'd1);
         o_rd = rd_of(p);
         chk("rdata", rd_of(p), exp_load(s, uns, a));
      end else if (lg && we) begin
         ref_store(s, a, wd);
      end
      $display("txn port=%s we=%0d size=%0d uns=%0d addr=0x%04h wdata=0x%08h wait=%0d rdata=0x%08h",
               p ? "B" : "A", we, s, uns, a, wd, waited, o_rd);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int          w;
      logic [3:0]  o_we;
      logic [31:0] o_wd, o_rd;
      logic [31:0] wda, wdb;

      for (int a = 0; a < 256; a++) ref_b[a] = init_byte(a);
      clear_reqs();
      drive(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 14'h0, 32'h1234_5678);

      // Reset: requests are ignored, outputs are quiet.
      @(negedge clk);
      chk("rst_gnt", 32'(bus.a_gnt_o), 32'd0);
      chk("rst_mem_we", 32'(bus.mem_we_o), 32'd0);
      chk("rst_rvalid", 32'({bus.a_rvalid_o, bus.b_rvalid_o}), 32'd0);
      chk("rst_err", 32'({bus.a_err_o, bus.b_err_o}), 32'd0);
      chk("rst_rdata", bus.a_rdata_o | bus.b_rdata_o, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      mem_init = 1'b0;
      clear_reqs();
      rst = 1'b0;

      // Byte store/load with extension.
      do_txn(1'b0, 1'b1, 2'b00, 1'b0, 14'h3, 32'h1234_56A5, w, o_we, o_wd, o_rd);
      chk("tp1_we", 32'(o_we), 32'h8);
      chk("tp1_wdata", o_wd, 32'hA5A5_A5A5);
      do_txn(1'b0, 1'b0, 2'b00, 1'b0, 14'h3, 32'h0, w, o_we, o_wd, o_rd);
      chk("tp1_lb", o_rd, 32'hFFFF_FFA5);
      do_txn(1'b0, 1'b0, 2'b00, 1'b1, 14'h3, 32'h0, w, o_we, o_wd, o_rd);
      chk("tp1_lbu", o_rd, 32'h0000_00A5);

      // Half store/load.
      do_txn(1'b0, 1'b1, 2'b01, 1'b0, 14'h2, 32'hDEAD_8001, w, o_we, o_wd, o_rd);
      chk("tp2_we", 32'(o_we), 32'hC);
      chk("tp2_wdata", o_wd, 32'h8001_8001);
      do_txn(1'b0, 1'b0, 2'b01, 1'b1, 14'h2, 32'h0, w, o_we, o_wd, o_rd);
      chk("tp2_lhu", o_rd, 32'h0000_8001);
      do_txn(1'b1, 1'b0, 2'b01, 1'b0, 14'h2, 32'h0, w, o_we, o_wd, o_rd);
      chk("tp2_lh_b", o_rd, 32'hFFFF_8001);

      // Misaligned and illegal accesses.
      do_txn(1'b0, 1'b0, 2'b10, 1'b0, 14'h6, 32'h0, w, o_we, o_wd, o_rd);
      do_txn(1'b0, 1'b0, 2'b01, 1'b0, 14'h1, 32'h0, w, o_we, o_wd, o_rd);
      do_txn(1'b0, 1'b0, 2'b11, 1'b0, 14'h0, 32'h0, w, o_we, o_wd, o_rd);
      do_txn(1'b1, 1'b1, 2'b10, 1'b0, 14'h6, 32'hFFFF_FFFF, w, o_we, o_wd, o_rd);
      chk("tp3_store_we", 32'(o_we), 32'h0);

      // Continuous contention: A,A,A,A,B repeating.
      wda = 32'hAAAA_0001;
      wdb = 32'hBBBB_0002;
      step();
      drive(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 14'h40, wda);
      drive(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 14'h44, wdb);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         chk("starve_gnt_a", 32'(bus.a_gnt_o), 32'((i % 5) != 4));
         chk("starve_gnt_b", 32'(bus.b_gnt_o), 32'((i % 5) == 4));
         chk("starve_we", 32'(bus.mem_we_o), 32'hF);
         $display("contend cycle=%0d gnt_a=%0d gnt_b=%0d", i, bus.a_gnt_o, bus.b_gnt_o);
         step();
      end
      clear_reqs();
      ref_store(2'b10, 14'h40, wda);
      ref_store(2'b10, 14'h44, wdb);

      // A load while B waits out RD_RESP.
      step();
      drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 14'h40, 32'h0);
      drive(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 14'h20, 32'hC0DE_F00D);
      @(negedge clk);
      chk("ld_b_gnt_a", 32'(bus.a_gnt_o), 32'd1);
      chk("ld_b_gnt_b0", 32'(bus.b_gnt_o), 32'd0);
      step();
      drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 14'h3C, 32'h0);
      @(negedge clk);
      chk("rresp_no_gnt_b", 32'(bus.b_gnt_o), 32'd0);
      chk("rresp_addr", 32'(bus.mem_addr_o), 32'h40);
      chk("rresp_we", 32'(bus.mem_we_o), 32'h0);
      step();
      @(negedge clk);
      chk("idle_gnt_b", 32'(bus.b_gnt_o), 32'd1);
      chk("idle_b_addr", 32'(bus.mem_addr_o), 32'h20);
      chk("sim_rvalid_a", 32'(bus.a_rvalid_o), 32'd1);
      chk("sim_rdata_a", bus.a_rdata_o, exp_load(2'b10, 1'b0, 14'h40));
      $display("overlap rdata_a=0x%08h gnt_b=%0d", bus.a_rdata_o, bus.b_gnt_o);
      step();
      clear_reqs();
      ref_store(2'b10, 14'h20, 32'hC0DE_F00D);

      // Reset in RD_RESP.
      drive(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 14'h5, 32'h0);
      @(negedge clk);
      chk("mr_gnt", 32'(bus.a_gnt_o), 32'd1);
      step();
      clear_reqs();
      #2;
      rst = 1'b1;
      drive(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 14'h8, 32'h5555_5555);
      #1;
      chk("mr_gnt_rst", 32'(bus.a_gnt_o), 32'd0);
      chk("mr_we_rst", 32'(bus.mem_we_o), 32'd0);
      chk("mr_rvalid_rst", 32'({bus.a_rvalid_o, bus.b_rvalid_o}), 32'd0);
      chk("mr_rdata_rst", bus.a_rdata_o, 32'd0);
      clear_reqs();
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mr_no_rvalid", 32'({bus.a_rvalid_o, bus.b_rvalid_o, bus.a_err_o, bus.b_err_o}), 32'd0);
         step();
      end
      do_txn(1'b0, 1'b0, 2'b00, 1'b0, 14'h5, 32'h0, w, o_we, o_wd, o_rd);
      chk("mr_first_gnt_wait", 32'(w), 32'd0);

      // Random single-port traffic against the reference memory.
      for (int i = 0; i < 40; i++) begin
         bit          rp, rwe, runs;
         logic [1:0]  rs;
         logic [ADDR_W-1:0] ra;
         rp   = 1'($urandom_range(0, 1));
         rwe  = 1'($urandom_range(0, 1));
         runs = 1'($urandom_range(0, 1));
         rs   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         ra   = ADDR_W'($urandom_range(0, 63));
         do_txn(rp, rwe, rs, runs, ra, $urandom, w, o_we, o_wd, o_rd);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Two-requester controller in front of the byte-lane data memory.
- Port A (core load/store unit) has priority; port B (debug/boot loader) gets guaranteed service through a starvation counter.
- Converts size/address into per-lane write enables and replicated write data, and detects misalignment.
- Holds the memory address through the synchronous read cycle and sign/zero-extends read data.

Parameters:
- ADDR_W, 14, byte-address width of the memory port.
- DATA_W, 32, data width; fixed 4 byte lanes.
- STARVE_MAX, 4, consecutive contested A grants before B is forced a grant.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- a_req_i  in  1  port A request; held with its fields until a_gnt_o
- a_we_i  in  1  1 = store, 0 = load
- a_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- a_uns_i  in  1  load zero-extend when 1, sign-extend when 0
- a_addr_i  in  ADDR_W  byte address
- a_wdata_i  in  DATA_W  store data, right-aligned
- a_gnt_o  out  1  request accepted this cycle (combinational)
- a_rvalid_o  out  1  load data valid, single-cycle pulse
- a_rdata_o  out  DATA_W  extended load data; 0 when a_rvalid_o = 0
- a_err_o  out  1  misaligned/illegal access, single-cycle pulse
- b_*  as a_* for port B
- mem_we_o  out  4  lane write enables
- mem_addr_o  out  ADDR_W  memory byte address
- mem_wdata_o  out  DATA_W  lane-replicated write data
- mem_rdata_i  in  DATA_W  memory read data, valid one cycle after address; requested item right-aligned in low bits

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high. Reset forces state IDLE, starvation counter 0, and all registered outputs 0 (rvalid, err, rdata). gnt_o and mem_we_o are 0 while rst is high.
- States:
  - IDLE: grants allowed.
  - RD_RESP: one cycle; no grants; mem_addr_o driven from the registered address; mem_we_o = 0.
- Arbitration in IDLE:
  - Only one requester: grant it.
  - Both request: grant A, unless starve_cnt == STARVE_MAX, then grant B.
  - starve_cnt increments when A is granted while b_req_i = 1; clears when B is granted or b_req_i = 0; saturates at STARVE_MAX.
- Granted access drives mem_addr_o combinationally from the winner's address in the grant cycle.
- Alignment check: legal when byte (any address), half with addr[0] = 0, or word with addr[1:0] = 0. Size 11 is always illegal.
- Illegal access: granted, mem_we_o = 0, no state change, winner's err_o pulses the next cycle, no rvalid.
- Store (legal):
  - mem_we_o in the grant cycle: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'hF.
  - mem_wdata_o: byte replicated to all 4 lanes, half replicated to both halves, word as-is.
  - Completes in one cycle; no response; next grant possible the following cycle.
- Load (legal):
  - Grant cycle: address to memory; the winner's id, size, uns and address are registered; next state RD_RESP.
  - RD_RESP: mem_addr_o held equal to the registered address. Winner's rvalid_o and rdata_o are registered and appear the cycle after RD_RESP, so load latency is 2 cycles after gnt.
  - Extension: byte gives {24{~uns & d[7]}, d[7:0]}; half gives {16{~uns & d[15]}, d[15:0]}; word is d.
  - Load throughput is 1 per 2 cycles. A request arriving in RD_RESP waits; the grant is evaluated in the next IDLE cycle.
- Simultaneous events: a response to one port and a grant to the other in the same cycle are allowed.
- Reset mid-read: no pending rvalid or err is produced after reset releases.

Test Plan:
- A store byte 0xA5 @0x0003, then A load byte signed @0x0003 -> mem_we_o = 4'b1000 with mem_wdata_o = 0xA5A5A5A5; load gives a_rvalid_o 2 cycles after gnt with a_rdata_o = 0xFFFFFFA5; unsigned load gives 0x000000A5.
- A store half 0x8001 @0x0002 -> mem_we_o = 4'b1100; mem_wdata_o = 0x80018001. A load half unsigned @0x0002 -> a_rdata_o = 0x00008001.
- Word load @0x0006, half @0x0001, size 11 -> granted, mem_we_o = 0, a_err_o pulse the next cycle, a_rvalid_o never set.
- A and B both requesting word stores continuously (STARVE_MAX = 4) -> grant pattern A,A,A,A,B repeating; starve_cnt clears after the B grant.
- A load, B request raised in the grant cycle -> B not granted in RD_RESP; B granted in the following IDLE cycle. During RD_RESP mem_addr_o keeps A's address even if a_addr_i changes.
- rst asserted in RD_RESP -> all outputs 0 immediately; no rvalid after release; first request afterwards is granted in its first cycle.
